// File: rtl/elevator_pkg.sv
// Shared encodings for the elevator dispatcher: FSM states, travel direction and the
// "no floor blocked" marker used on buttons_blocked.
package elevator_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    MOVE_UP,
    MOVE_DOWN,
    DOOR_OPEN
  } state_t;

  typedef enum logic {
    UP   = 1'b0,
    DOWN = 1'b1
  } dir_t;

  localparam logic [3:0] BLOCK_NONE = 4'hF;

  function automatic int maxInt(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/elevator_dispatcher_timer.sv
// elev_timer: loadable down-counter shared by car travel and door dwell.
// done is high whenever the count sits at zero.
module elev_timer #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             done
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_value;
    end else if (count_q != '0) begin
      count_q <= count_q - 1'b1;
    end
  end

  assign done = (count_q == '0);

endmodule

// File: rtl/elevator_dispatcher.sv
// Collective up/down elevator dispatcher: scans latched requests, moves the car, opens the door
// and pulses inactivate bits for served calls. Optional door hold input: ELEVATOR_DOOR_HOLD_EN.
module elevator_dispatcher
  import elevator_pkg::*;
#(
  parameter int BUTTONS_WIDTH = 8,
  parameter int MOVE_CYCLES   = 16,
  parameter int DOOR_CYCLES   = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [BUTTONS_WIDTH-1:0] active_in_levels,
  input  logic [BUTTONS_WIDTH-1:0] active_out_up_levels,
  input  logic [BUTTONS_WIDTH-1:0] active_out_down_levels,
`ifdef ELEVATOR_DOOR_HOLD_EN
  input  logic                     door_hold,
`endif
  output logic [BUTTONS_WIDTH-1:0] inactivate_in_levels,
  output logic [BUTTONS_WIDTH-1:0] inactivate_out_up_levels,
  output logic [BUTTONS_WIDTH-1:0] inactivate_out_down_levels,
  output logic [3:0]               buttons_blocked,
  output logic [3:0]               current_floor,
  output logic                     motor_up,
  output logic                     motor_down,
  output logic                     door_open
);

  localparam int TIMER_W = $clog2(maxInt(MOVE_CYCLES, DOOR_CYCLES) + 1);
  localparam logic [TIMER_W-1:0] MOVE_LOAD = TIMER_W'(MOVE_CYCLES - 1);
  localparam logic [TIMER_W-1:0] DOOR_LOAD = TIMER_W'(DOOR_CYCLES - 1);

  state_t                   state_q;
  dir_t                     dir_q;
  logic [3:0]               floor_q;
  logic [3:0]               blocked_q;
  logic                     motorUp_q;
  logic                     motorDown_q;
  logic                     doorOpen_q;
  logic [BUTTONS_WIDTH-1:0] inactIn_q;
  logic [BUTTONS_WIDTH-1:0] inactUp_q;
  logic [BUTTONS_WIDTH-1:0] inactDown_q;

  logic [BUTTONS_WIDTH-1:0] req;
  logic [BUTTONS_WIDTH-1:0] here;
  logic                     above;
  logic                     below;
  logic                     reqHere;
  logic                     furtherInDir;
  logic                     stopHere;
  logic                     serveUp;
  logic                     serveDown;
  logic                     goUp;
  logic                     goDown;
  logic                     holdActive;
  logic                     timerLoad;
  logic [TIMER_W-1:0]       timerValue;
  logic                     timerDone;

  assign req = active_in_levels | active_out_up_levels | active_out_down_levels;

  always_comb begin
    here  = '0;
    above = 1'b0;
    below = 1'b0;
    for (int i = 0; i < BUTTONS_WIDTH; i++) begin
      if (4'(i) == floor_q) here[i] = 1'b1;
      if (4'(i) > floor_q) above = above | req[i];
      if (4'(i) < floor_q) below = below | req[i];
    end
  end

  assign reqHere      = |(req & here);
  assign furtherInDir = (dir_q == UP) ? above : below;
  assign stopHere     = (|(active_in_levels & here))
                      || ((dir_q == UP) && (|(active_out_up_levels & here)))
                      || ((dir_q == DOWN) && (|(active_out_down_levels & here)))
                      || (reqHere && !furtherInDir);

  // A hall call against the current direction is also served when nothing lies further
  // ahead, otherwise a turnaround stop would reopen the door on the same call forever.
  assign serveUp   = (dir_q == UP) || !above || !furtherInDir;
  assign serveDown = (dir_q == DOWN) || !below || !furtherInDir;

  assign goUp   = above && ((dir_q == UP) || !below);
  assign goDown = below && !((dir_q == UP) && above);

`ifdef ELEVATOR_DOOR_HOLD_EN
  assign holdActive = door_hold;
`else
  assign holdActive = 1'b0;
`endif

  assign timerLoad  = (state_q == CHECK) || ((state_q == DOOR_OPEN) && holdActive);
  assign timerValue = ((state_q == CHECK) && !stopHere) ? MOVE_LOAD : DOOR_LOAD;

  elev_timer #(
    .WIDTH(TIMER_W)
  ) u_timer (
    .clk       (clk),
    .reset     (reset),
    .load      (timerLoad),
    .load_value(timerValue),
    .done      (timerDone)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      dir_q       <= UP;
      floor_q     <= 4'd0;
      blocked_q   <= BLOCK_NONE;
      motorUp_q   <= 1'b0;
      motorDown_q <= 1'b0;
      doorOpen_q  <= 1'b0;
      inactIn_q   <= '0;
      inactUp_q   <= '0;
      inactDown_q <= '0;
    end else begin
      inactIn_q   <= '0;
      inactUp_q   <= '0;
      inactDown_q <= '0;
      case (state_q)
        IDLE: begin
          if (req != '0) state_q <= CHECK;
        end
        CHECK: begin
          if (stopHere) begin
            state_q     <= DOOR_OPEN;
            doorOpen_q  <= 1'b1;
            blocked_q   <= floor_q;
            inactIn_q   <= active_in_levels & here;
            inactUp_q   <= serveUp ? (active_out_up_levels & here) : '0;
            inactDown_q <= serveDown ? (active_out_down_levels & here) : '0;
          end else if (goUp) begin
            state_q   <= MOVE_UP;
            dir_q     <= UP;
            motorUp_q <= 1'b1;
          end else if (goDown) begin
            state_q     <= MOVE_DOWN;
            dir_q       <= DOWN;
            motorDown_q <= 1'b1;
          end else begin
            state_q <= IDLE;
          end
        end
        MOVE_UP: begin
          if (timerDone) begin
            floor_q   <= floor_q + 4'd1;
            motorUp_q <= 1'b0;
            state_q   <= CHECK;
          end
        end
        MOVE_DOWN: begin
          if (timerDone) begin
            floor_q     <= floor_q - 4'd1;
            motorDown_q <= 1'b0;
            state_q     <= CHECK;
          end
        end
        DOOR_OPEN: begin
          if (timerDone && !holdActive) begin
            doorOpen_q <= 1'b0;
            blocked_q  <= BLOCK_NONE;
            state_q    <= CHECK;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign inactivate_in_levels       = inactIn_q;
  assign inactivate_out_up_levels   = inactUp_q;
  assign inactivate_out_down_levels = inactDown_q;
  assign buttons_blocked            = blocked_q;
  assign current_floor              = floor_q;
  assign motor_up                   = motorUp_q;
  assign motor_down                 = motorDown_q;
  assign door_open                  = doorOpen_q;

endmodule

// File: tb/tb_elevator_dispatcher.sv
// Directed bench for elevator_dispatcher (8 floors, 4 move cycles, 8 door cycles); models the
// button block by clearing request levels when inactivate pulses appear.
module tb_elevator_dispatcher;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] inLevels;
  logic [W-1:0] upLevels;
  logic [W-1:0] downLevels;
  logic         doorHold;
  logic [W-1:0] inactivate_in_levels;
  logic [W-1:0] inactivate_out_up_levels;
  logic [W-1:0] inactivate_out_down_levels;
  logic [3:0]   buttons_blocked;
  logic [3:0]   current_floor;
  logic         motor_up;
  logic         motor_down;
  logic         door_open;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int pulses;

  always #5 clk = ~clk;

  elevator_dispatcher #(
    .BUTTONS_WIDTH(W),
    .MOVE_CYCLES  (4),
    .DOOR_CYCLES  (8)
  ) dut (
    .clk                       (clk),
    .reset                     (reset),
    .active_in_levels          (inLevels),
    .active_out_up_levels      (upLevels),
    .active_out_down_levels    (downLevels),
`ifdef ELEVATOR_DOOR_HOLD_EN
    .door_hold                 (doorHold),
`endif
    .inactivate_in_levels      (inactivate_in_levels),
    .inactivate_out_up_levels  (inactivate_out_up_levels),
    .inactivate_out_down_levels(inactivate_out_down_levels),
    .buttons_blocked           (buttons_blocked),
    .current_floor             (current_floor),
    .motor_up                  (motor_up),
    .motor_down                (motor_down),
    .door_open                 (door_open)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", tag, actual, expected, cyc);
    end
  endtask

  task automatic applyStimulus(input logic [W-1:0] inV, input logic [W-1:0] upV, input logic [W-1:0] downV);
    inLevels   = inV;
    upLevels   = upV;
    downLevels = downV;
    cyc        = 0;
  endtask

  // One clock: sample at the falling edge, then let the button-block model drop served bits.
  task automatic waitCycle();
    @(negedge clk);
    cyc++;
    if (!reset) checkOutput("floor_range", 32'(current_floor < 4'd8), 1);
    inLevels   = inLevels & ~inactivate_in_levels;
    upLevels   = upLevels & ~inactivate_out_up_levels;
    downLevels = downLevels & ~inactivate_out_down_levels;
  endtask

  task automatic stepTo(input int n);
    while (cyc < n) waitCycle();
  endtask

  task automatic doReset();
    @(negedge clk);
    reset = 1'b1;
    inLevels = '0;
    upLevels = '0;
    downLevels = '0;
    doorHold = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset      = 1'b1;
    inLevels   = '0;
    upLevels   = '0;
    downLevels = '0;
    doorHold   = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("rst_floor", 32'(current_floor), 0);
    checkOutput("rst_motor_up", 32'(motor_up), 0);
    checkOutput("rst_motor_down", 32'(motor_down), 0);
    checkOutput("rst_door", 32'(door_open), 0);
    checkOutput("rst_blocked", 32'(buttons_blocked), 'hF);
    checkOutput("rst_inact", 32'(inactivate_in_levels | inactivate_out_up_levels | inactivate_out_down_levels), 0);
    reset = 1'b0;

    // Single cabin call to floor 3
    applyStimulus(8'h08, 8'h00, 8'h00);
    stepTo(1);  checkOutput("cab_check_motor", 32'(motor_up), 0);
    stepTo(2);  checkOutput("cab_motor_on", 32'(motor_up), 1);
                checkOutput("cab_floor0", 32'(current_floor), 0);
    stepTo(5);  checkOutput("cab_motor_hold", 32'(motor_up), 1);
    stepTo(6);  checkOutput("cab_motor_gap", 32'(motor_up), 0);
                checkOutput("cab_floor1", 32'(current_floor), 1);
    stepTo(16); checkOutput("cab_floor3", 32'(current_floor), 3);
                checkOutput("cab_door_pre", 32'(door_open), 0);
    stepTo(17); checkOutput("cab_door_open", 32'(door_open), 1);
                checkOutput("cab_pulse", 32'(inactivate_in_levels), 'h08);
                checkOutput("cab_blocked", 32'(buttons_blocked), 3);
    stepTo(18); checkOutput("cab_pulse_end", 32'(inactivate_in_levels), 0);
    stepTo(24); checkOutput("cab_door_last", 32'(door_open), 1);
    stepTo(25); checkOutput("cab_door_closed", 32'(door_open), 0);
                checkOutput("cab_unblocked", 32'(buttons_blocked), 'hF);
    stepTo(27); checkOutput("cab_idle_motor", 32'(motor_up | motor_down), 0);
                checkOutput("cab_idle_floor", 32'(current_floor), 3);

    // Hall-up call at the car's own floor
    doReset();
    applyStimulus(8'h00, 8'h01, 8'h00);
    stepTo(1);  checkOutput("own_check_door", 32'(door_open), 0);
    stepTo(2);  checkOutput("own_door", 32'(door_open), 1);
                checkOutput("own_motor", 32'(motor_up | motor_down), 0);
                checkOutput("own_pulse_up", 32'(inactivate_out_up_levels), 'h01);
                checkOutput("own_pulse_other", 32'(inactivate_in_levels | inactivate_out_down_levels), 0);
                checkOutput("own_blocked", 32'(buttons_blocked), 0);
    stepTo(3);  checkOutput("own_pulse_end", 32'(inactivate_out_up_levels), 0);
    stepTo(9);  checkOutput("own_door_last", 32'(door_open), 1);
    stepTo(10); checkOutput("own_door_closed", 32'(door_open), 0);

    // Collective scan: up 2, cabin 5, down 4
    doReset();
    applyStimulus(8'h20, 8'h04, 8'h10);
    stepTo(6);  checkOutput("scan_floor1", 32'(current_floor), 1);
    stepTo(11); checkOutput("scan_floor2", 32'(current_floor), 2);
    stepTo(12); checkOutput("scan_door2", 32'(door_open), 1);
                checkOutput("scan_pulse_up2", 32'(inactivate_out_up_levels), 'h04);
                checkOutput("scan_other2", 32'(inactivate_in_levels | inactivate_out_down_levels), 0);
                checkOutput("scan_blocked2", 32'(buttons_blocked), 2);
    stepTo(20); checkOutput("scan_close2", 32'(door_open), 0);
    stepTo(21); checkOutput("scan_leave2", 32'(motor_up), 1);
    stepTo(30); checkOutput("scan_floor4_up", 32'(current_floor), 4);
    stepTo(31); checkOutput("scan_pass4", 32'(motor_up), 1);
                checkOutput("scan_pass4_door", 32'(door_open), 0);
    stepTo(35); checkOutput("scan_floor5", 32'(current_floor), 5);
    stepTo(36); checkOutput("scan_door5", 32'(door_open), 1);
                checkOutput("scan_pulse_in5", 32'(inactivate_in_levels), 'h20);
                checkOutput("scan_pulse_dn5", 32'(inactivate_out_down_levels), 0);
                checkOutput("scan_blocked5", 32'(buttons_blocked), 5);
    stepTo(44); checkOutput("scan_close5", 32'(door_open), 0);
    stepTo(45); checkOutput("scan_reverse", 32'(motor_down), 1);
                checkOutput("scan_reverse_up", 32'(motor_up), 0);
    stepTo(49); checkOutput("scan_floor4_dn", 32'(current_floor), 4);
    stepTo(50); checkOutput("scan_door4", 32'(door_open), 1);
                checkOutput("scan_pulse_dn4", 32'(inactivate_out_down_levels), 'h10);
                checkOutput("scan_blocked4", 32'(buttons_blocked), 4);
    stepTo(59); checkOutput("scan_idle", 32'(door_open | motor_up | motor_down), 0);

    // Reset while moving up out of floor 2
    doReset();
    applyStimulus(8'h80, 8'h00, 8'h00);
    stepTo(12); checkOutput("rmid_floor2", 32'(current_floor), 2);
                checkOutput("rmid_moving", 32'(motor_up), 1);
    reset = 1'b1;
    inLevels = '0;
    #1;
    checkOutput("rmid_motor_drop", 32'(motor_up), 0);
    checkOutput("rmid_floor0", 32'(current_floor), 0);
    checkOutput("rmid_blocked", 32'(buttons_blocked), 'hF);
    @(negedge clk);
    reset = 1'b0;

`ifdef ELEVATOR_DOOR_HOLD_EN
    // Door held for 20 cycles after opening at floor 0
    doReset();
    applyStimulus(8'h01, 8'h00, 8'h00);
    stepTo(2);
    checkOutput("hold_door_open", 32'(door_open), 1);
    pulses = (inactivate_in_levels != '0) ? 1 : 0;
    doorHold = 1'b1;
    while (cyc < 29) begin
      waitCycle();
      if (inactivate_in_levels != '0) pulses++;
      if (cyc == 22) doorHold = 1'b0;
      if (cyc == 26) checkOutput("hold_door_mid", 32'(door_open), 1);
    end
    checkOutput("hold_door_last", 32'(door_open), 1);
    stepTo(30);
    checkOutput("hold_door_closed", 32'(door_open), 0);
    checkOutput("hold_pulse_count", 32'(pulses), 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
